// File: rtl/mitec2_dramseq_if.sv
// Z80-side strobes/address bits and the DRAM strobe outputs of the
// MITEC-2 cartridge DRAM sequencer.
interface mitec2_dramseq_if;
    logic MREQ;
    logic RD;
    logic WR;
    logic RFSH;
    logic A7;
    logic A14;
    logic A15;
    logic RAS1;
    logic RAS2;
    logic CAS1;
    logic CAS2;
    logic MUX;
    logic RAMA7;
    logic WAIT;

    // CPU / bus side
    modport master (
        output MREQ, RD, WR, RFSH, A7, A14, A15,
        input  RAS1, RAS2, CAS1, CAS2, MUX, RAMA7, WAIT
    );

    // Sequencer side
    modport slave (
        input  MREQ, RD, WR, RFSH, A7, A14, A15,
        output RAS1, RAS2, CAS1, CAS2, MUX, RAMA7, WAIT
    );
endinterface

// File: rtl/mitec2_dramseq.sv
// Clocked DRAM strobe sequencer: synchronises the Z80 strobes, then runs
// row/column/refresh cycles with clock-counted spacing and a guaranteed
// precharge, holding /WAIT while an access is blocked by precharge.
module mitec2_dramseq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned T_RCD       = 1,
    parameter int unsigned T_MC        = 1,
    parameter int unsigned T_RP        = 2
) (
    input  logic            CLK,
    input  logic            RESETN,
    mitec2_dramseq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_ACT,
        S_REF,
        S_PRE
    } state_t;

    localparam logic [3:0] RCD_LAST = 4'(T_RCD - 1);
    localparam logic [3:0] MC_LAST  = 4'(T_MC - 1);
    localparam logic [3:0] RP_LAST  = 4'(T_RP - 1);

    // {MREQ, RD, WR, RFSH} per synchroniser stage
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];

    logic mreq_s, rd_s, wr_s, rfsh_s;
    logic acc, ref_req;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       armed_q, armed_d;
    logic       bank_q, bank_d;
    logic       a7l_q, a7l_d;
    logic       ras1_q, ras1_d;
    logic       ras2_q, ras2_d;
    logic       cas1_q, cas1_d;
    logic       cas2_q, cas2_d;
    logic       mux_q, mux_d;
    logic       rama7_q, rama7_d;
    logic       wait_q, wait_d;
    logic       ras_on;

    // Synchroniser shift: stage 0 samples the raw strobes
    always_comb begin
        sync_d[0] = {bus.MREQ, bus.RD, bus.WR, bus.RFSH};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops, idle (high) out of reset
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign {mreq_s, rd_s, wr_s, rfsh_s} = sync_q[SYNC_STAGES-1];
    assign acc     = !mreq_s && bus.A15 && rfsh_s && (!rd_s || !wr_s);
    assign ref_req = !mreq_s && !rfsh_s;

    // Next state, counters and strobe levels; outputs derive from the next
    // state so every strobe leaves a flop directly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q || mreq_s;
        bank_d  = bank_q;
        a7l_d   = a7l_q;
        unique case (state_q)
            S_IDLE: begin
                if (armed_q && ref_req) begin
                    state_d = S_REF;
                    armed_d = 1'b0;
                end else if (armed_q && acc) begin
                    state_d = S_ROW;
                    armed_d = 1'b0;
                    bank_d  = bus.A14;
                    a7l_d   = bus.A7;
                    cnt_d   = '0;
                end
            end
            S_ROW: begin
                if (mreq_s) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end else if (cnt_q == RCD_LAST) begin
                    state_d = S_COL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_COL: begin
                if (mreq_s) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end else if (cnt_q == MC_LAST) begin
                    state_d = S_ACT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACT, S_REF: begin
                if (mreq_s) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (cnt_q == RP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        ras_on  = (state_d == S_ROW) || (state_d == S_COL) || (state_d == S_ACT);
        ras1_d  = !((ras_on && !bank_d) || (state_d == S_REF));
        ras2_d  = !((ras_on && bank_d) || (state_d == S_REF));
        mux_d   = !((state_d == S_COL) || (state_d == S_ACT));
        cas1_d  = !((state_d == S_ACT) && !bank_d);
        cas2_d  = !((state_d == S_ACT) && bank_d);
        rama7_d = ((state_d == S_COL) || (state_d == S_ACT)) && a7l_d;
        wait_d  = !(acc && ((state_d == S_PRE) || (state_d == S_ROW) ||
                            (state_d == S_COL) ||
                            ((state_d == S_IDLE) && armed_d)));
    end

    // Sequencer state and registered strobes; reset forces all strobes idle
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            bank_q  <= 1'b0;
            a7l_q   <= 1'b0;
            ras1_q  <= 1'b1;
            ras2_q  <= 1'b1;
            cas1_q  <= 1'b1;
            cas2_q  <= 1'b1;
            mux_q   <= 1'b1;
            rama7_q <= 1'b0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            bank_q  <= bank_d;
            a7l_q   <= a7l_d;
            ras1_q  <= ras1_d;
            ras2_q  <= ras2_d;
            cas1_q  <= cas1_d;
            cas2_q  <= cas2_d;
            mux_q   <= mux_d;
            rama7_q <= rama7_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.RAS1  = ras1_q;
    assign bus.RAS2  = ras2_q;
    assign bus.CAS1  = cas1_q;
    assign bus.CAS2  = cas2_q;
    assign bus.MUX   = mux_q;
    assign bus.RAMA7 = rama7_q;
    assign bus.WAIT  = wait_q;

endmodule

// File: tb/tb_mitec2_dramseq.sv
// Bench for mitec2_dramseq: two instances (default timing, and slow timing
// with 3-stage synchronisers) share the same Z80 stimulus and are compared
// every clock against a timestamp-based model of the DRAM cycle rules.
`timescale 1ns/1ps
module tb_mitec2_dramseq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mreq = 1'b1, rd = 1'b1, wr = 1'b1, rfsh = 1'b1;
    logic a7 = 1'b0, a14 = 1'b0, a15 = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mitec2_dramseq_if bus0();
    mitec2_dramseq_if bus1();

    assign bus0.MREQ = mreq;  assign bus1.MREQ = mreq;
    assign bus0.RD   = rd;    assign bus1.RD   = rd;
    assign bus0.WR   = wr;    assign bus1.WR   = wr;
    assign bus0.RFSH = rfsh;  assign bus1.RFSH = rfsh;
    assign bus0.A7   = a7;    assign bus1.A7   = a7;
    assign bus0.A14  = a14;   assign bus1.A14  = a14;
    assign bus0.A15  = a15;   assign bus1.A15  = a15;

    mitec2_dramseq u0 (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus0)
    );

    mitec2_dramseq #(
        .SYNC_STAGES (3),
        .T_RCD       (2),
        .T_MC        (3),
        .T_RP        (3)
    ) u1 (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus1)
    );

    // {RAS1, RAS2, MUX, CAS1, CAS2, RAMA7, WAIT}
    localparam logic [6:0] IDLE_V = 7'b1111101;
    logic [6:0] obs [2];
    always_comb begin
        obs[0] = {bus0.RAS1, bus0.RAS2, bus0.MUX, bus0.CAS1, bus0.CAS2, bus0.RAMA7, bus0.WAIT};
        obs[1] = {bus1.RAS1, bus1.RAS2, bus1.MUX, bus1.CAS1, bus1.CAS2, bus1.RAMA7, bus1.WAIT};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int ss_of   [2] = '{2, 3};
    int trcd_of [2] = '{1, 2};
    int tmc_of  [2] = '{1, 3};
    int trp_of  [2] = '{2, 3};

    // raw strobe samples: index i holds the value seen i+1 edges ago
    logic hm [4], hr [4], hw [4], hf [4];
    int   t;
    bit   armed [2], active [2], is_ref [2], bnk [2], a7m [2];
    int   st [2], rel [2];
    logic [6:0] expv [2];

    task automatic model_step(input int k);
        logic ms, rs, ws, fs, accv, refv, inrc, inpre;
        int e;
        logic [6:0] v;
        ms = hm[ss_of[k]-1];
        rs = hr[ss_of[k]-1];
        ws = hw[ss_of[k]-1];
        fs = hf[ss_of[k]-1];
        accv = !ms && a15 && fs && (!rs || !ws);
        refv = !ms && !fs;
        if (active[k]) begin
            if (ms) begin
                active[k] = 1'b0;
                rel[k]    = t;
            end
        end else if (t >= rel[k] + trp_of[k] + 1 && armed[k] && (refv || accv)) begin
            active[k] = 1'b1;
            is_ref[k] = refv;
            bnk[k]    = a14;
            a7m[k]    = a7;
            st[k]     = t;
            armed[k]  = 1'b0;
        end
        if (ms) armed[k] = 1'b1;
        e = t - st[k];
        v = IDLE_V;
        if (active[k]) begin
            if (is_ref[k]) begin
                v[6] = 1'b0;
                v[5] = 1'b0;
            end else begin
                if (bnk[k]) v[5] = 1'b0; else v[6] = 1'b0;
                if (e >= trcd_of[k]) begin
                    v[4] = 1'b0;
                    v[1] = a7m[k];
                end
                if (e >= trcd_of[k] + tmc_of[k]) begin
                    if (bnk[k]) v[2] = 1'b0; else v[3] = 1'b0;
                end
            end
        end
        inrc  = active[k] && !is_ref[k] && (e < trcd_of[k] + tmc_of[k]);
        inpre = !active[k] && (t < rel[k] + trp_of[k]);
        if (accv && (inrc || inpre || (!active[k] && !inpre && armed[k]))) v[0] = 1'b0;
        expv[k] = v;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hm[i] = 1'b1; hr[i] = 1'b1; hw[i] = 1'b1; hf[i] = 1'b1;
            end
            t = 0;
            for (int k = 0; k < 2; k++) begin
                armed[k]  = 1'b1;
                active[k] = 1'b0;
                rel[k]    = -100;
                st[k]     = 0;
                expv[k]   = IDLE_V;
            end
        end else begin
            t++;
            for (int k = 0; k < 2; k++) model_step(k);
            for (int i = 3; i > 0; i--) begin
                hm[i] = hm[i-1]; hr[i] = hr[i-1]; hw[i] = hw[i-1]; hf[i] = hf[i-1];
            end
            hm[0] = mreq; hr[0] = rd; hw[0] = wr; hf[0] = rfsh;
        end
    end

    // per-clock comparison on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("cyc%0d_u%0d", t, k), {25'd0, obs[k]}, {25'd0, expv[k]});
        end
    end

    // RAS1/CAS1 falling-edge counter for the long-hold case
    bit mon_en = 1'b0;
    int ras_falls, cas_falls;
    logic prev_ras1 = 1'b1, prev_cas1 = 1'b1;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_ras1 && !bus0.RAS1) ras_falls++;
            if (prev_cas1 && !bus0.CAS1) cas_falls++;
        end
        prev_ras1 = bus0.RAS1;
        prev_cas1 = bus0.CAS1;
    end

    // ---------------- stimulus ----------------
    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        if (n > 0) #2;
    endtask

    // kind: 0 read, 1 write, 2 refresh, 3 read with A15=0, 4 MREQ only
    task automatic drive_cycle(input int kind, input bit b14, input bit b7, input int low_clks);
        a14  = b14;
        a7   = b7;
        a15  = (kind == 0 || kind == 1 || kind == 4);
        rd   = !(kind == 0 || kind == 3);
        wr   = !(kind == 1);
        rfsh = !(kind == 2);
        mreq = 1'b0;
        repeat (low_clks) @(posedge clk);
        #2;
        mreq = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;
        rfsh = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mreq  = 1'b0;
        rd    = 1'b0;
        a15   = 1'b1;
        a14   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_u0", {25'd0, obs[0]}, {25'd0, IDLE_V});
        check_eq("reset_u1", {25'd0, obs[1]}, {25'd0, IDLE_V});
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        mreq = 1'b1;
        rd   = 1'b1;
        gap(4);

        drive_cycle(1, 1'b1, 1'b1, 12); gap(3);
        drive_cycle(2, 1'b0, 1'b0, 5);  gap(1);
        drive_cycle(0, 1'b0, 1'b1, 8);  gap(5);
        drive_cycle(3, 1'b1, 1'b1, 5);  gap(2);
        drive_cycle(4, 1'b0, 1'b1, 5);  gap(4);
        drive_cycle(0, 1'b1, 1'b0, 1);  gap(6);
        drive_cycle(0, 1'b0, 1'b0, 2);  gap(6);

        ras_falls = 0;
        cas_falls = 0;
        mon_en    = 1'b1;
        drive_cycle(0, 1'b0, 1'b1, 46);
        gap(8);
        mon_en = 1'b0;
        check_eq("hold_ras_count", ras_falls, 1);
        check_eq("hold_cas_count", cas_falls, 1);

        a15 = 1'b1; a14 = 1'b0; rd = 1'b0; mreq = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_u0", {25'd0, obs[0]}, {25'd0, IDLE_V});
        check_eq("async_rst_u1", {25'd0, obs[1]}, {25'd0, IDLE_V});
        #3;
        mreq = 1'b1;
        rd   = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        gap(4);

        repeat (300) begin
            drive_cycle($urandom_range(0, 4), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(1, 10));
            gap($urandom_range(0, 4));
        end
        gap(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mitec2_dramseq.md
# mitec2_dramseq

Clocked sequencer for the cartridge DRAM strobes (/RAS1, /RAS2, /MUX, /CAS1, /CAS2, RAMA7) on the MITEC-2 glue CPLD. It replaces the fixed-delay combinational strobe generation. It synchronises the Z80 bus strobes to the master clock and runs row/column/refresh cycles with programmable clock-counted spacing. It also enforces DRAM precharge and drives /WAIT while an access is held off by precharge.

## Interface
Parameters:
- SYNC_STAGES, 2: flops per synchroniser on MREQ/RD/WR/RFSH; legal range 2..3.
- T_RCD, 1: clocks from /RAS low to /MUX low; legal range 1..15.
- T_MC, 1: clocks from /MUX low to /CAS low; legal range 1..15.
- T_RP, 2: minimum clocks spent in PRE after any cycle; legal range 1..15.

Ports:
- CLK  in  1  master clock, 14.318 MHz (4x CPU clock); all state on rising edge.
- RESETN  in  1  reset, asynchronous, active-low.
- MREQ, RD, WR, RFSH  in  1 each  Z80 strobes, active-low, asynchronous to CLK.
- A7, A14, A15  in  1 each  CPU address bits.
- RAS1, RAS2  out  1  active-low row strobes: bank 1 (A14=0) and bank 2 (A14=1).
- CAS1, CAS2  out  1  active-low column strobes, per bank.
- MUX  out  1  active-low; low selects column address.
- RAMA7  out  1  DRAM address bit 7 during column phase.
- WAIT  out  1  active-low Z80 /WAIT.

## Operation
- Synchronisers: each of MREQ/RD/WR/RFSH passes through SYNC_STAGES flops. The flops reset to 1. Synced versions are mreq_s, rd_s, wr_s, rfsh_s.
- Addresses: A7, A14, A15 are used unsynchronised. They are stable before MREQ falls.
- Decode on synced signals:
  - acc = !mreq_s & A15 & rfsh_s & (!rd_s | !wr_s)
  - ref = !mreq_s & !rfsh_s
- Arm flag:
  - Set on any clock where mreq_s=1.
  - Cleared when IDLE starts a cycle.
  - IDLE starts a cycle only when armed, so each MREQ assertion gives at most one cycle.
- Outputs are all registered and glitch-free. Reset values: RAS1=RAS2=CAS1=CAS2=MUX=WAIT=1, RAMA7=0; state IDLE; armed=1; counters 0.
- States:
  - IDLE
    - If armed & ref: go to REF.
    - Else if armed & acc: go to ROW, latch bank=A14 and a7l=A7.
    - Otherwise stay.
    - ref has priority (acc and ref are mutually exclusive by RFSH, but the priority is fixed).
  - ROW: selected RASx=0; count T_RCD clocks, then go to COL.
  - COL: RASx=0, MUX=0, RAMA7=a7l; count T_MC clocks, then go to ACT.
  - ACT: RASx=0, MUX=0, CASx=0, RAMA7=a7l; hold until mreq_s=1, then go to PRE.
  - REF: RAS1=RAS2=0; CAS, MUX stay high (RAS-only refresh); hold until mreq_s=1, then go to PRE.
  - PRE: all strobes high, RAMA7=0; count T_RP clocks, then go to IDLE.
- Abort: mreq_s=1 while in ROW or COL sends the state to PRE on the next edge. All strobes go high and the full T_RP is still enforced.
- WAIT:
  - Driven 0 while acc=1 and the state is PRE, ROW or COL.
  - Driven 0 while acc=1, the state is IDLE and armed (the decode clock).
  - Returns to 1 on the edge that enters ACT, or on abort.
  - Never asserted for refresh or for non-A15 accesses.
- Reset mid-cycle: all strobes return high asynchronously; the state becomes IDLE with armed=1. No precharge guarantee across reset.

## Timing
- Clock numbering: the first clock where acc=1 is edge N.
- RAS low from edge N+1.
- MUX low from edge N+1+T_RCD.
- CAS low from edge N+1+T_RCD+T_MC.
- Defaults: RAS at N+1, MUX at N+2, CAS at N+3. From MREQ falling, CAS is low within SYNC_STAGES+4 clocks.
- Deassert: on the edge after mreq_s first reads 1, RASx, MUX, CASx and RAMA7 all go high/0 on the same edge.
- Minimum RAS-high time between cycles is T_RP+1 clocks: T_RP in PRE plus the IDLE decode clock.
- Back-to-back: a request decoded during PRE is serviced on the first IDLE clock. RAS falls exactly T_RP+1 clocks after the previous rise.
- Strobe ordering is never violated: CAS low implies MUX low; MUX low implies RAS low.

## Test plan
- Reset: hold RESETN=0 with MREQ=0, RD=0, A15=1 -> all strobes and WAIT=1, RAMA7=0. After release, read cycle A15=1, A14=0: RAS1 low N+1, MUX N+2, CAS1 N+3; RAS2/CAS2 stay 1.
- Write cycle A15=1, A14=1, A7=1, with T_RCD=2 and T_MC=3 -> RAS2 at N+1, MUX at N+3, CAS2 and RAMA7=1 at N+6; all release one clock after mreq_s=1.
- Refresh (MREQ=0, RFSH=0, A15=0) -> RAS1=RAS2=0, CAS/MUX=1, WAIT=1; after MREQ rises, a read issued 1 clock later gets RAS low exactly T_RP+1=3 clocks after the refresh RAS rose, with WAIT=0 until CAS falls.
- Access with A15=0, or with MREQ=0 and RD=WR=1 -> no strobe activity, WAIT=1.
- Abort: MREQ rises at N+1 with defaults -> state goes ROW->PRE, CAS never asserts, WAIT returns 1, RAS high for at least 3 clocks.
- MREQ held low 40 clocks after ACT -> exactly one RAS/CAS assertion; assert RESETN=0 mid-ACT -> strobes high asynchronously.
